// File: rtl/jtframe_spidl_pkg.sv
// jtframe_spidl_pkg
// Shared definitions for the data_io download SPI master:
//   - data_io command bytes and file start/end markers
//   - frame FSM state encoding
//   - helpers giving the state that follows a given one and the command
//     byte that opens each frame
// Optional feature macro used by the files importing this package:
//   JTFRAME_SPIDL_READBACK_EN (MISO capture of payload bytes)
package jtframe_spidl_pkg;

  localparam logic [7:0] CMD_INDEX = 8'h55;
  localparam logic [7:0] CMD_TX    = 8'h53;
  localparam logic [7:0] CMD_TXDAT = 8'h54;
  localparam logic [7:0] TX_START  = 8'hFF;
  localparam logic [7:0] TX_END    = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_IDX,
    ST_GAP1,
    ST_STA,
    ST_GAP2,
    ST_DAT,
    ST_GAP3,
    ST_END,
    ST_GAP4,
    ST_DONE
  } state_t;

  // The download is a fixed chain of frames and gaps
  function automatic state_t next_state(input state_t s);
    case (s)
      ST_IDLE: next_state = ST_IDX;
      ST_IDX:  next_state = ST_GAP1;
      ST_GAP1: next_state = ST_STA;
      ST_STA:  next_state = ST_GAP2;
      ST_GAP2: next_state = ST_DAT;
      ST_DAT:  next_state = ST_GAP3;
      ST_GAP3: next_state = ST_END;
      ST_END:  next_state = ST_GAP4;
      ST_GAP4: next_state = ST_DONE;
      default: next_state = ST_IDLE;
    endcase
  endfunction

  // First byte sent when a frame state is entered
  function automatic logic [7:0] frame_cmd(input state_t s);
    case (s)
      ST_IDX:  frame_cmd = CMD_INDEX;
      ST_DAT:  frame_cmd = CMD_TXDAT;
      default: frame_cmd = CMD_TX;
    endcase
  endfunction

endpackage

// File: rtl/jtframe_spidl_shift.sv
// jtframe_spidl_shift
// Byte shifter and SCK generator for SPI mode 0, MSB first.
// Each bit cell is CLKDIV cycles with SCK low (MOSI set at the start of the
// low phase) followed by CLKDIV cycles with SCK high. A load restarts the
// divider from zero, so a frame always begins with a full low phase.
// Ports:
//   clk_sys, rst        clock, asynchronous active-high reset
//   load, load_byte     start shifting a new byte (accepted when idle or in
//                       the cycle byte_done is high)
//   load_payload        marks the loaded byte as payload (readback only)
//   miso                slave data in (readback only)
//   rd_data, rd_valid   captured payload byte and one-cycle strobe
//                       (readback only)
//   sck, mosi           SPI clock and data out
//   active              a byte is being shifted
//   byte_done           the final SCK fall of the byte happens at the next
//                       edge; a load in this cycle chains without a gap
// Optional feature macro: JTFRAME_SPIDL_READBACK_EN
module jtframe_spidl_shift #(
  parameter int CLKDIV = 4
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_byte,
`ifdef JTFRAME_SPIDL_READBACK_EN
  input  logic       load_payload,
  input  logic       miso,
  output logic [7:0] rd_data,
  output logic       rd_valid,
`endif
  output logic       sck,
  output logic       mosi,
  output logic       active,
  output logic       byte_done
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  logic [7:0]    sr_reg;
  logic [2:0]    bit_reg;
  logic [DW-1:0] div_reg;
  logic          sck_reg;
  logic          mosi_reg;
  logic          active_reg;
  logic          phase_end;

`ifdef JTFRAME_SPIDL_READBACK_EN
  logic          payload_reg;
  logic [7:0]    cap_reg;
  logic [7:0]    rd_data_reg;
  logic          rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
`endif

  assign phase_end = active_reg && (div_reg == DIV_LAST);
  assign byte_done = phase_end && sck_reg && (bit_reg == 3'd7);
  assign sck       = sck_reg;
  assign mosi      = mosi_reg;
  assign active    = active_reg;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sr_reg       <= 8'h00;
      bit_reg      <= 3'd0;
      div_reg      <= '0;
      sck_reg      <= 1'b0;
      mosi_reg     <= 1'b0;
      active_reg   <= 1'b0;
`ifdef JTFRAME_SPIDL_READBACK_EN
      payload_reg  <= 1'b0;
      cap_reg      <= 8'h00;
      rd_data_reg  <= 8'h00;
      rd_valid_reg <= 1'b0;
`endif
    end else begin
`ifdef JTFRAME_SPIDL_READBACK_EN
      rd_valid_reg <= 1'b0;
`endif
      if (load) begin
        // Load has priority: when chained it replaces the final SCK fall,
        // which the new byte's low phase continues seamlessly.
        sr_reg     <= load_byte;
        mosi_reg   <= load_byte[7];
        sck_reg    <= 1'b0;
        div_reg    <= '0;
        bit_reg    <= 3'd0;
        active_reg <= 1'b1;
`ifdef JTFRAME_SPIDL_READBACK_EN
        payload_reg <= load_payload;
`endif
      end else if (active_reg) begin
        if (phase_end) begin
          div_reg <= '0;
          if (!sck_reg) begin
            sck_reg <= 1'b1;
`ifdef JTFRAME_SPIDL_READBACK_EN
            cap_reg <= {cap_reg[6:0], miso};
            if (payload_reg && bit_reg == 3'd7) begin
              rd_data_reg  <= {cap_reg[6:0], miso};
              rd_valid_reg <= 1'b1;
            end
`endif
          end else begin
            sck_reg <= 1'b0;
            if (bit_reg == 3'd7) begin
              active_reg <= 1'b0;
            end else begin
              bit_reg  <= bit_reg + 3'd1;
              sr_reg   <= {sr_reg[6:0], 1'b0};
              mosi_reg <= sr_reg[6];
            end
          end
        end else begin
          div_reg <= div_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jtframe_spi_dlmaster.sv
// jtframe_spi_dlmaster
// Host-side SPI master for the MiST data_io ROM download protocol. Sends
//   55 idx | 53 FF | 54 payload... | 53 00
// as four SS2-low frames separated by SSGAP-cycle SS2-high gaps, then pulses
// done. Payload arrives over a valid/ready byte stream ending at data_last.
// Ports:
//   clk_sys, rst          clock, asynchronous active-high reset
//   start, index          begin a download (IDLE only); index is captured
//   data, data_valid,
//   data_last, data_ready payload stream; data_ready marks the transfer
//   spi_sck, spi_ss2,
//   spi_di, spi_do        SPI pins (spi_do used only with readback)
//   busy, done            transfer in progress / end pulse
//   rd_data, rd_valid     MISO bytes captured during payload (readback only)
// Optional feature macro: JTFRAME_SPIDL_READBACK_EN
module jtframe_spi_dlmaster
  import jtframe_spidl_pkg::*;
#(
  parameter int CLKDIV = 4,
  parameter int SSGAP  = 8
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] index,
  input  logic [7:0] data,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       spi_sck,
  output logic       spi_ss2,
  output logic       spi_di,
  input  logic       spi_do,
  output logic       busy,
  output logic       done
`ifdef JTFRAME_SPIDL_READBACK_EN
  ,
  output logic [7:0] rd_data,
  output logic       rd_valid
`endif
);

  localparam int CMAX = (SSGAP > CLKDIV) ? SSGAP : CLKDIV;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] GAP_LAST  = CW'(SSGAP - 1);
  localparam logic [CW-1:0] TAIL_LAST = CW'(CLKDIV - 1);

  state_t        state_reg;
  logic [7:0]    index_reg;
  logic [CW-1:0] cnt_reg;
  logic          byte_sel_reg;   // second byte of a two-byte frame loaded
  logic          tail_reg;       // last byte out, holding SS2 low CLKDIV cycles
  logic          last_seen_reg;  // byte with data_last already accepted
  logic          ss_reg;
  logic          busy_reg;
  logic          done_reg;

  logic          load;
  logic [7:0]    load_byte;
  logic          sh_active;
  logic          byte_done;

  // Loads are decided combinationally so that a new byte enters the shifter
  // on the same edge as the previous byte's final SCK fall (or as SS2 falls).
  always_comb begin
    load       = 1'b0;
    load_byte  = 8'h00;
    data_ready = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          load_byte = CMD_INDEX;
        end
      end
      ST_IDX, ST_STA, ST_END: begin
        if (!tail_reg && byte_done && !byte_sel_reg) begin
          load      = 1'b1;
          load_byte = (state_reg == ST_IDX) ? index_reg :
                      (state_reg == ST_STA) ? TX_START : TX_END;
        end
      end
      ST_GAP1, ST_GAP2, ST_GAP3: begin
        if (cnt_reg == GAP_LAST) begin
          load      = 1'b1;
          load_byte = frame_cmd(next_state(state_reg));
        end
      end
      ST_DAT: begin
        // The command byte is loaded on entry, so an empty shifter here
        // always means payload is due; whole bytes only.
        if (!tail_reg && !last_seen_reg && data_valid &&
            (byte_done || !sh_active)) begin
          data_ready = 1'b1;
          load       = 1'b1;
          load_byte  = data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      index_reg     <= 8'h00;
      cnt_reg       <= '0;
      byte_sel_reg  <= 1'b0;
      tail_reg      <= 1'b0;
      last_seen_reg <= 1'b0;
      ss_reg        <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            index_reg     <= index;
            ss_reg        <= 1'b0;
            busy_reg      <= 1'b1;
            byte_sel_reg  <= 1'b0;
            tail_reg      <= 1'b0;
            last_seen_reg <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= ST_IDX;
          end
        end
        ST_IDX, ST_STA, ST_DAT, ST_END: begin
          if (!tail_reg) begin
            if (state_reg == ST_DAT) begin
              if (data_ready && data_last) last_seen_reg <= 1'b1;
              if (byte_done && last_seen_reg) begin
                tail_reg <= 1'b1;
                cnt_reg  <= '0;
              end
            end else if (byte_done) begin
              if (!byte_sel_reg) begin
                byte_sel_reg <= 1'b1;
              end else begin
                tail_reg <= 1'b1;
                cnt_reg  <= '0;
              end
            end
          end else if (cnt_reg == TAIL_LAST) begin
            ss_reg    <= 1'b1;
            tail_reg  <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= next_state(state_reg);
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_GAP1, ST_GAP2, ST_GAP3, ST_GAP4: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg      <= '0;
            byte_sel_reg <= 1'b0;
            if (state_reg == ST_GAP4) begin
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              ss_reg    <= 1'b0;
              state_reg <= next_state(state_reg);
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign spi_ss2 = ss_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

`ifdef JTFRAME_SPIDL_READBACK_EN
  logic load_payload;
  // Payload loads are exactly the accepted stream transfers
  assign load_payload = data_ready;
`else
  logic unused_spi_do;
  assign unused_spi_do = spi_do;
`endif

  jtframe_spidl_shift #(
    .CLKDIV       (CLKDIV)
  ) u_shift (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .load         (load),
    .load_byte    (load_byte),
`ifdef JTFRAME_SPIDL_READBACK_EN
    .load_payload (load_payload),
    .miso         (spi_do),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
`endif
    .sck          (spi_sck),
    .mosi         (spi_di),
    .active       (sh_active),
    .byte_done    (byte_done)
  );

endmodule

// File: tb/tb_jtframe_spi_dlmaster.sv
// Bench for jtframe_spi_dlmaster: a table of directed downloads with
// hand-written expected SPI byte streams (9'h100 marks an SS2 rise), plus
// hand-written reset, busy-restart and hold sequences.
module tb_jtframe_spi_dlmaster;

  localparam int CLKDIV = 4;
  localparam int SSGAP  = 8;
  localparam logic [8:0] E = 9'h100;  // end of frame (SS2 rises)
  localparam logic [8:0] P = 9'h1FF;  // unused table slot

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] index = 8'h00;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_last = 1'b0;
  logic       spi_do = 1'b0;
  logic       data_ready, spi_sck, spi_ss2, spi_di, busy, done;
`ifdef JTFRAME_SPIDL_READBACK_EN
  logic [7:0] rd_data;
  logic       rd_valid;
`endif

  always #5 clk_sys = ~clk_sys;

  jtframe_spi_dlmaster #(.CLKDIV(CLKDIV), .SSGAP(SSGAP)) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .start      (start),
    .index      (index),
    .data       (data),
    .data_valid (data_valid),
    .data_last  (data_last),
    .data_ready (data_ready),
    .spi_sck    (spi_sck),
    .spi_ss2    (spi_ss2),
    .spi_di     (spi_di),
    .spi_do     (spi_do),
    .busy       (busy),
    .done       (done)
`ifdef JTFRAME_SPIDL_READBACK_EN
    ,
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
`endif
  );

  typedef struct packed {
    logic [7:0]        idx;
    logic [2:0]        nbytes;
    logic [0:3][7:0]   pay;
    logic [2:0]        hold_pos;   // payload position preceded by a 100-cycle hold; 7 = none
    logic              restart;    // pulse start while busy
    logic [4:0]        exp_len;
    logic [0:15][8:0]  exp;
  } vec_t;

  vec_t tbl [5];

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- slave / line monitor (sole owner of its state) -------
  int         cyc = 0;
  logic       prev_ss = 1'b1, prev_sck = 1'b0, prev_di = 1'b0;
  int         bitc = 0;
  logic [7:0] sh = 8'h00;
  logic [8:0] rx_q [$];
  int         gap_q [$];
  int         gap_run = 0, di_age = 0, viol = 0, abort_cnt = 0;
  int         done_cnt = 0, rises = 0, fall_cyc = 0, sckf_cyc = 0;
  logic       first_rise = 1'b0;
`ifdef JTFRAME_SPIDL_READBACK_EN
  logic [7:0] miso_pat = 8'hC3;
  int         rdv_cnt = 0, rdbad = 0;
`endif

  always @(negedge clk_sys) begin
    cyc++;
    if (rst) begin
      if (bitc != 0) abort_cnt++;
      bitc = 0;
      first_rise = 1'b0;
    end else begin
      if (spi_di != prev_di && spi_sck) viol++;           // MOSI moved while SCK high
      if (prev_ss && !spi_ss2) begin
        gap_q.push_back(gap_run);
        fall_cyc = cyc;
        first_rise = 1'b1;
        bitc = 0;
      end
      if (!prev_sck && spi_sck) begin
        rises++;
        if (spi_ss2) viol++;                               // SCK with SS2 high
        if (di_age < CLKDIV) viol++;                       // setup too short
        if (first_rise && (cyc - fall_cyc) != CLKDIV) viol++;
        first_rise = 1'b0;
        sh = {sh[6:0], spi_di};
        bitc++;
        if (bitc == 8) begin
          rx_q.push_back({1'b0, sh});
          bitc = 0;
        end
      end
      if (prev_sck && !spi_sck) sckf_cyc = cyc;
      if (!prev_ss && spi_ss2) begin
        rx_q.push_back(E);
        if (bitc != 0) viol++;                             // partial byte
        if ((cyc - sckf_cyc) != CLKDIV) viol++;            // SS2 trailing time
        bitc = 0;
        gap_run = 0;
      end
      if (spi_ss2) gap_run++;
      if (done) done_cnt++;
`ifdef JTFRAME_SPIDL_READBACK_EN
      if (rd_valid) begin
        rdv_cnt++;
        if (rd_data != 8'hC3) rdbad++;
      end
`endif
    end
    di_age = (spi_di != prev_di) ? 1 : di_age + 1;
    prev_ss = spi_ss2;
    prev_sck = spi_sck;
    prev_di = spi_di;
`ifdef JTFRAME_SPIDL_READBACK_EN
    spi_do = miso_pat[3'(7 - bitc)];
`endif
  end

  // ---------------- helpers ----------------------------------------------
  task automatic tick();
    @(negedge clk_sys);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int k;
    data = b;
    data_last = last;
    data_valid = 1'b1;
    for (k = 0; k < 5000; k++) begin
      #1;
      if (data_ready) break;
      tick();
    end
    chk("byte_accepted", {31'd0, k < 5000}, 32'd1);
    tick();
    data_valid = 1'b0;
    data_last = 1'b0;
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int rx_base, gap_base, done_base, viol_base, r_mid, k;
`ifdef JTFRAME_SPIDL_READBACK_EN
    int rdv_base, rdbad_base;
`endif
    tick();
    rx_base = rx_q.size();
    gap_base = gap_q.size();
    done_base = done_cnt;
    viol_base = viol;
`ifdef JTFRAME_SPIDL_READBACK_EN
    rdv_base = rdv_cnt;
    rdbad_base = rdbad;
`endif
    index = v.idx;
    start = 1'b1;
    tick();
    start = 1'b0;
    index = 8'hFF;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    if (v.restart) begin
      repeat (20) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int b = 0; b < 32'(v.nbytes); b++) begin
      if (b == 32'(v.hold_pos)) begin
        repeat (80) tick();
        r_mid = rises;
        repeat (20) tick();
        chk("hold_sck_flat", rises - r_mid, 0);
        chk("hold_ss_low", {31'd0, spi_ss2}, 32'd0);
        chk("hold_sck_low", {31'd0, spi_sck}, 32'd0);
      end
      send_byte(v.pay[b], b == 32'(v.nbytes) - 1);
      if (v.restart && b == 0) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    for (k = 0; k < 20000 && !done; k++) tick();
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("busy_at_done", {31'd0, busy}, 32'd1);
    tick();
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("done_count", done_cnt - done_base, 1);
    chk("stream_len", rx_q.size() - rx_base, 32'(v.exp_len));
    for (int i = 0; i < 32'(v.exp_len); i++) begin
      if (rx_base + i < rx_q.size())
        chk($sformatf("vec%0d_byte%0d", vi, i), {23'd0, rx_q[rx_base + i]}, {23'd0, v.exp[i]});
    end
    chk("gap_count", gap_q.size() - gap_base, 4);
    for (int g = 1; g < 4; g++) begin
      if (gap_base + g < gap_q.size())
        chk($sformatf("vec%0d_gap%0d", vi, g), gap_q[gap_base + g], SSGAP);
    end
    chk("line_timing", viol - viol_base, 0);
`ifdef JTFRAME_SPIDL_READBACK_EN
    chk("rd_valid_count", rdv_cnt - rdv_base, 32'(v.nbytes));
    chk("rd_data_c3", rdbad - rdbad_base, 0);
`endif
    $display("vec%0d idx=%02h bytes=%0d decoded=%0d", vi, v.idx, v.nbytes, rx_q.size() - rx_base);
  endtask

  // ---------------- stimulus ---------------------------------------------
  initial begin
    int done_base, ab_base, r0, k;

    tbl[0] = '{idx: 8'h00, nbytes: 3'd3, pay: {8'hA5, 8'h3C, 8'h81, 8'h00},
               hold_pos: 3'd7, restart: 1'b0, exp_len: 5'd14,
               exp: {9'h055, 9'h000, E, 9'h053, 9'h0FF, E, 9'h054, 9'h0A5,
                     9'h03C, 9'h081, E, 9'h053, 9'h000, E, P, P}};
    tbl[1] = '{idx: 8'h12, nbytes: 3'd3, pay: {8'h5A, 8'hF0, 8'h0F, 8'h00},
               hold_pos: 3'd1, restart: 1'b0, exp_len: 5'd14,
               exp: {9'h055, 9'h012, E, 9'h053, 9'h0FF, E, 9'h054, 9'h05A,
                     9'h0F0, 9'h00F, E, 9'h053, 9'h000, E, P, P}};
    tbl[2] = '{idx: 8'h7E, nbytes: 3'd1, pay: {8'h99, 8'h00, 8'h00, 8'h00},
               hold_pos: 3'd7, restart: 1'b0, exp_len: 5'd12,
               exp: {9'h055, 9'h07E, E, 9'h053, 9'h0FF, E, 9'h054, 9'h099,
                     E, 9'h053, 9'h000, E, P, P, P, P}};
    tbl[3] = '{idx: 8'h3C, nbytes: 3'd2, pay: {8'h01, 8'h80, 8'h00, 8'h00},
               hold_pos: 3'd7, restart: 1'b1, exp_len: 5'd13,
               exp: {9'h055, 9'h03C, E, 9'h053, 9'h0FF, E, 9'h054, 9'h001,
                     9'h080, E, 9'h053, 9'h000, E, P, P, P}};
    tbl[4] = '{idx: 8'hFF, nbytes: 3'd4, pay: {8'hFF, 8'h00, 8'hAA, 8'h55},
               hold_pos: 3'd3, restart: 1'b0, exp_len: 5'd15,
               exp: {9'h055, 9'h0FF, E, 9'h053, 9'h0FF, E, 9'h054, 9'h0FF,
                     9'h000, 9'h0AA, 9'h055, E, 9'h053, 9'h000, E, P}};

    // Reset state, with data_valid asserted to show ready stays low
    data_valid = 1'b1;
    repeat (3) tick();
    chk("rst_ss2", {31'd0, spi_ss2}, 32'd1);
    chk("rst_sck", {31'd0, spi_sck}, 32'd0);
    chk("rst_di", {31'd0, spi_di}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, data_ready}, 32'd0);
    data_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_ready", {31'd0, data_ready}, 32'd0);
    repeat (5) tick();

    for (int v = 0; v < 5; v++) run_vec(v, tbl[v]);

    // Reset during payload bit 4
    repeat (10) tick();
    done_base = done_cnt;
    ab_base = abort_cnt;
    index = 8'h44;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h11, 1'b0);
    r0 = rises;
    for (k = 0; k < 1000 && rises < r0 + 4; k++) tick();
    chk("rst_wait_bits", {31'd0, k < 1000}, 32'd1);
    chk("ss_low_before_rst", {31'd0, spi_ss2}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_ss2", {31'd0, spi_ss2}, 32'd1);
    chk("rst_mid_sck", {31'd0, spi_sck}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (200) tick();
    chk("rst_no_done", done_cnt - done_base, 0);
    chk("rst_abort_partial", abort_cnt - ab_base, 1);
    chk("rst_ss2_idle", {31'd0, spi_ss2}, 32'd1);
    $display("reset-abort sequence checked");

    run_vec(5, tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
